// File: rtl/uart_pkg.sv
// UART shared definitions: FSM states, framing constants, default bit period.
// Used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;
  localparam int   BITS_PER_BYTE  = 8;
  localparam int   BYTES_PER_WORD = 2;
  localparam int   DATA_W         = BITS_PER_BYTE * BYTES_PER_WORD;
  localparam int   CLK_PER_BIT    = 21;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period cycle counter; bit_end marks the last cycle of a bit.
// Clear has priority and the count wraps on every bit boundary.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned clk_per_bit = CLK_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic bit_end
);

  localparam int unsigned CW = $clog2(clk_per_bit);
  localparam logic [CW-1:0] LAST = CW'(clk_per_bit - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_end = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || bit_end) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 16-bit UART transmitter: two gapless 8N1 frames, low byte first.
// All outputs registered; the line level is decided together with the next state.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned clk_per_bit = CLK_PER_BIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_start,
  output logic              tx_ready,
  output logic              serial_out,
  output logic              tx_busy,
  output logic              tx_done
);

  uart_state_e       state_q, state_d;
  logic [2:0]        bit_q, bit_d;
  logic              byte_q, byte_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              ser_q, ser_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              bit_end;

  uart_baud_cnt #(
    .clk_per_bit(clk_per_bit)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_q == IDLE),
    .en     (state_q != IDLE),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    ser_d   = ser_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ser_d   = STOP_BIT;
        ready_d = 1'b1;
        if (tx_start && ready_q) begin
          shift_d = tx_data;
          byte_d  = 1'b0;
          bit_d   = '0;
          state_d = START;
          ser_d   = START_BIT;
          ready_d = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          ser_d   = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          // Shift after every data bit so the high byte lands in [7:0].
          shift_d = shift_q >> 1;
          if (bit_q == 3'(BITS_PER_BYTE - 1)) begin
            state_d = STOP;
            ser_d   = STOP_BIT;
          end else begin
            bit_d = bit_q + 3'd1;
            ser_d = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!byte_q) begin
            byte_d  = 1'b1;
            state_d = START;
            ser_d   = START_BIT;
          end else begin
            state_d = IDLE;
            ser_d   = STOP_BIT;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        ser_d   = STOP_BIT;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      byte_q  <= 1'b0;
      shift_q <= '0;
      ser_q   <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      ser_q   <= ser_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign serial_out = ser_q;
  assign tx_ready   = ready_q;
  assign tx_busy    = ~ready_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: line waveform, handshake, reset and bit-period sweep.
// A second instance runs with a 2-cycle bit period.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] tx_data = '0;
  logic        tx_start = 1'b0;
  logic        tx_ready, serial_out, tx_busy, tx_done;

  logic [15:0] s_data = '0;
  logic        s_start = 1'b0;
  logic        s_ready, s_out, s_busy, s_done;

  int n_chk = 0;
  int n_fail = 0;

  always #10 clk = ~clk;

  uart_tx #(.clk_per_bit(21)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_ready  (tx_ready),
    .serial_out(serial_out),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  uart_tx #(.clk_per_bit(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (s_data),
    .tx_start  (s_start),
    .tx_ready  (s_ready),
    .serial_out(s_out),
    .tx_busy   (s_busy),
    .tx_done   (s_done)
  );

  // Expected line level k cycles after the accept edge.
  function automatic logic exp_line(input logic [15:0] w,
                                    input int cpb, input int k);
    int b, f, p;
    logic [15:0] wv;
    wv = w;
    b = k / cpb;
    f = b / 10;
    p = b % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return wv[f*8 + p - 1];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tx_start = 1'b0;
    #60;
    n_chk++;
    if ({serial_out, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_vals got=%b want=1100",
               {serial_out, tx_ready, tx_busy, tx_done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      n_chk++;
      if ({serial_out, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%b want=1100", i,
                 {serial_out, tx_ready, tx_busy, tx_done});
      end
    end
  endtask

  task automatic test_single();
    logic [15:0] w;
    logic [15:0] rx;
    int ndone;
    w = 16'hAC35;
    rx = '0;
    ndone = 0;
    tx_data = w;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    for (int k = 0; k < 420; k++) begin
      n_chk++;
      if (serial_out !== exp_line(w, 21, k) || tx_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL single_line k=%0d got=%b/%b want=%b/1", k,
                 serial_out, tx_busy, exp_line(w, 21, k));
      end
      if (tx_done) ndone++;
      if (k % 21 == 10 && (k / 21) % 10 != 0 && (k / 21) % 10 != 9)
        rx[((k / 21) / 10) * 8 + (k / 21) % 10 - 1] = serial_out;
      step();
    end
    n_chk++;
    if ({tx_done, tx_ready, serial_out} !== 3'b111 || ndone != 0) begin
      n_fail++;
      $display("FAIL single_done got=%b early=%0d want=111 early=0",
               {tx_done, tx_ready, serial_out}, ndone);
    end
    n_chk++;
    if (rx !== w) begin
      n_fail++;
      $display("FAIL single_loopback got=%h want=%h", rx, w);
    end
    step();
    n_chk++;
    if (tx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done_width got=%b want=0", tx_done);
    end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] w;
    w = 16'hAC35;
    tx_data = w;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    for (int k = 0; k < 420; k++) begin
      n_chk++;
      if (serial_out !== exp_line(w, 21, k) || tx_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_line k=%0d got=%b/%b want=%b/0", k,
                 serial_out, tx_ready, exp_line(w, 21, k));
      end
      tx_start = (k == 100);
      if (k == 100) tx_data = 16'h1234;
      step();
    end
    tx_start = 1'b0;
    n_chk++;
    if ({tx_done, tx_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL busy_done got=%b want=11", {tx_done, tx_ready});
    end
    for (int i = 0; i < 30; i++) begin
      step();
      n_chk++;
      if ({serial_out, tx_ready} !== 2'b11) begin
        n_fail++;
        $display("FAIL busy_after cyc=%0d got=%b want=11", i,
                 {serial_out, tx_ready});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w0, w1;
    logic e;
    int t1, t2;
    w0 = 16'h00FF;
    w1 = 16'hFF00;
    t1 = -1;
    t2 = -1;
    tx_data = w0;
    tx_start = 1'b1;
    step();
    tx_data = w1;
    for (int j = 0; j <= 841; j++) begin
      if (j < 420) e = exp_line(w0, 21, j);
      else if (j == 420) e = 1'b1;
      else if (j <= 840) e = exp_line(w1, 21, j - 421);
      else e = 1'b1;
      n_chk++;
      if (serial_out !== e) begin
        n_fail++;
        $display("FAIL b2b_line j=%0d got=%b want=%b", j, serial_out, e);
      end
      if (tx_done) begin
        if (t1 < 0) t1 = j;
        else t2 = j;
      end
      if (j == 421) tx_start = 1'b0;
      if (j < 841) step();
    end
    n_chk++;
    if (t1 != 420 || t2 != 841) begin
      n_fail++;
      $display("FAIL b2b_done_times got=%0d,%0d want=420,841", t1, t2);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [15:0] w;
    int ndone;
    w = 16'hAC35;
    ndone = 0;
    tx_data = w;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    repeat (90) step();
    n_chk++;
    if (serial_out !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_pre got=%b want=0", serial_out);
    end
    #4;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({serial_out, tx_ready, tx_busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL mid_async got=%b want=110",
               {serial_out, tx_ready, tx_busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 450; i++) begin
      step();
      if (tx_done) ndone++;
    end
    n_chk++;
    if (ndone != 0 || {serial_out, tx_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_after done=%0d got=%b want=0 11", ndone,
               {serial_out, tx_ready});
    end
    w = 16'h5A5A;
    tx_data = w;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    for (int k = 0; k < 420; k++) begin
      n_chk++;
      if (serial_out !== exp_line(w, 21, k)) begin
        n_fail++;
        $display("FAIL mid_next k=%0d got=%b want=%b", k, serial_out,
                 exp_line(w, 21, k));
      end
      step();
    end
    n_chk++;
    if (tx_done !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_next_done got=%b want=1", tx_done);
    end
    step();
  endtask

  task automatic test_sweep();
    logic [15:0] w;
    int nbusy;
    w = 16'hFFFF;
    nbusy = 0;
    s_data = w;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      n_chk++;
      if (s_out !== exp_line(w, 2, k) || s_done !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep_line k=%0d got=%b/%b want=%b/0", k, s_out,
                 s_done, exp_line(w, 2, k));
      end
      if (s_busy) nbusy++;
      step();
    end
    n_chk++;
    if (nbusy != 40 || {s_done, s_ready, s_busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL sweep_end busy=%0d got=%b want=40 110", nbusy,
               {s_done, s_ready, s_busy});
    end
    step();
    n_chk++;
    if (s_done !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_done_width got=%b want=0", s_done);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
